range_frame_tx: RTL and testbench

Frame transmitter for the range-finder stream interface. Buffers samples written by upstream logic, then emits a framed sequence on the `data`/`go`/`finish` protocol: a one-cycle `go` with the first sample, body samples one per cycle, and `finish` with the last sample. The block captures the range the receiver returns during the `finish` cycle, so it acts as a self-contained stimulus source and result collector for the range finder.

---
 rtl/range_frame_pkg.sv | 8 +
 rtl/range_frame_fifo.sv | 43 ++++
 rtl/range_frame_tx.sv | 159 +++++++++++++++
 tb/tb_range_frame_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/range_frame_pkg.sv
// range_frame_pkg: shared types and constants for the range-finder frame interface
package range_frame_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/range_frame_fifo.sv
// range_frame_fifo: synchronous power-of-2 FIFO, pointers carry an extra wrap bit
module range_frame_fifo import range_frame_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + CW'(do_push);
        rd_ptr_d = rd_ptr_q + CW'(do_pop);
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/range_frame_tx.sv
// range_frame_tx: buffered go/finish frame transmitter with range capture; RANGE_FRAME_TX_EXPECT_EN adds a max-min checker
module range_frame_tx import range_frame_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count,
    input  logic                          send,
    output logic                          busy,
    output logic                          reject,
    output logic [WIDTH-1:0]              data_out,
    output logic                          go,
    output logic                          finish,
    input  logic [WIDTH-1:0]              range_in,
    input  logic                          range_error,
    output logic [WIDTH-1:0]              result,
    output logic                          result_valid,
    output logic                          result_err
`ifdef RANGE_FRAME_TX_EXPECT_EN
    ,
    output logic [WIDTH-1:0]              expected,
    output logic                          mismatch
`endif
);
    localparam int CW = count_width(DEPTH);
    tx_state_t state_q, state_d;
    logic [CW-1:0] len_q, len_d, sent_q, sent_d;
    logic [WIDTH-1:0] data_q, data_d, result_q, result_d, rd_data;
    logic busy_q, busy_d, reject_q, reject_d, go_q, go_d, finish_q, finish_d;
    logic result_valid_q, result_valid_d, result_err_q, result_err_d;
    logic pop, empty, accept;
`ifdef RANGE_FRAME_TX_EXPECT_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d, expected_q, expected_d;
    logic mismatch_q, mismatch_d;
`endif

    range_frame_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_en), .wr_data(wr_data), .pop(pop),
        .rd_data(rd_data), .full(full), .empty(empty), .count(count)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        sent_d         = sent_q;
        pop            = 1'b0;
        data_d         = '0;
        go_d           = 1'b0;
        finish_d       = 1'b0;
        reject_d       = 1'b0;
        result_valid_d = 1'b0;
        result_d       = result_q;
        result_err_d   = result_err_q;
        accept         = send && !empty && count >= CW'(2);
`ifdef RANGE_FRAME_TX_EXPECT_EN
        min_d      = min_q;
        max_d      = max_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                reject_d = send && !accept;
                if (accept) begin
                    pop     = 1'b1;
                    data_d  = rd_data;
                    go_d    = 1'b1;
                    len_d   = count;
                    sent_d  = CW'(1);
                    state_d = SEND;
`ifdef RANGE_FRAME_TX_EXPECT_EN
                    min_d = rd_data;
                    max_d = rd_data;
`endif
                end
            end
            SEND: begin
                if (finish_q) begin
                    result_d       = range_in;
                    result_err_d   = range_error;
                    result_valid_d = 1'b1;
                    state_d        = GAP;
`ifdef RANGE_FRAME_TX_EXPECT_EN
                    expected_d = max_q - min_q;
                    mismatch_d = (max_q - min_q) != range_in;
`endif
                end else begin
                    pop      = 1'b1;
                    data_d   = rd_data;
                    finish_d = sent_q == len_q - 1'b1;
                    sent_d   = sent_q + 1'b1;
`ifdef RANGE_FRAME_TX_EXPECT_EN
                    min_d = rd_data < min_q ? rd_data : min_q;
                    max_d = rd_data > max_q ? rd_data : max_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            len_q          <= '0;
            sent_q         <= '0;
            data_q         <= '0;
            busy_q         <= 1'b0;
            reject_q       <= 1'b0;
            go_q           <= 1'b0;
            finish_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_err_q   <= 1'b0;
`ifdef RANGE_FRAME_TX_EXPECT_EN
            min_q      <= '0;
            max_q      <= '0;
            expected_q <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            sent_q         <= sent_d;
            data_q         <= data_d;
            busy_q         <= busy_d;
            reject_q       <= reject_d;
            go_q           <= go_d;
            finish_q       <= finish_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_err_q   <= result_err_d;
`ifdef RANGE_FRAME_TX_EXPECT_EN
            min_q      <= min_d;
            max_q      <= max_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign reject       = reject_q;
    assign data_out     = data_q;
    assign go           = go_q;
    assign finish       = finish_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_err   = result_err_q;
`ifdef RANGE_FRAME_TX_EXPECT_EN
    assign expected = expected_q;
    assign mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_range_frame_tx.sv
// tb_range_frame_tx: randomized scoreboard bench for range_frame_tx with a queue-based frame model
module tb_range_frame_tx;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, send = 1'b0, range_error = 1'b0;
    logic [W-1:0] wr_data = '0, range_in = '0;
    logic full, busy, reject, go, finish, result_valid, result_err;
    logic [$clog2(D):0] count;
    logic [W-1:0] data_out, result;
`ifdef RANGE_FRAME_TX_EXPECT_EN
    logic [W-1:0] expected;
    logic mismatch;
`endif

    range_frame_tx #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full), .count(count),
        .send(send), .busy(busy), .reject(reject), .data_out(data_out), .go(go), .finish(finish),
        .range_in(range_in), .range_error(range_error), .result(result),
        .result_valid(result_valid), .result_err(result_err)
`ifdef RANGE_FRAME_TX_EXPECT_EN
        , .expected(expected), .mismatch(mismatch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] d; bit g; bit f;} samp_t;
    typedef struct {logic [W-1:0] r; bit e; logic [W-1:0] x; bit m;} res_t;
    samp_t exp_s[$];
    res_t exp_r[$];
    logic [W-1:0] mq[$];
    int exp_rej = 0, rv_seen = 0, errors = 0, checks = 0;
    bit in_frame = 0;
    samp_t ms;
    res_t mr;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic write(input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        if (mq.size() < D) mq.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic start_send(input bit force_rng, input logic [W-1:0] frng);
        int n;
        logic [W-1:0] mn, mx, s;
        n = mq.size();
        send = 1'b1;
        if (n >= 2) begin
            mn = '1;
            mx = '0;
            for (int i = 0; i < n; i++) begin
                s = mq.pop_front();
                mn = s < mn ? s : mn;
                mx = s > mx ? s : mx;
                exp_s.push_back('{s, i == 0, i == n - 1});
            end
            range_in = force_rng ? frng : mx - mn;
            range_error = 1'($urandom_range(0, 1));
            exp_r.push_back('{range_in, range_error, mx - mn, (mx - mn) != range_in});
        end else exp_rej++;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * D && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_drops", busy, 0);
    endtask

    task automatic do_send(input bit force_rng, input logic [W-1:0] frng);
        start_send(force_rng, frng);
        wait_idle();
    endtask

    task automatic level();
        chk("count", count, mq.size());
        chk("full", full, mq.size() == D);
    endtask

    always @(negedge clk) begin
        if (!rst_n) in_frame = 0;
        else begin
            if (go) in_frame = 1;
            if (in_frame) begin
                if (exp_s.size() == 0) chk("stray_sample", 1, 0);
                else begin
                    ms = exp_s.pop_front();
                    chk("data", data_out, ms.d);
                    chk("go", go, ms.g);
                    chk("finish", finish, ms.f);
                end
                if (finish) in_frame = 0;
            end else if (finish || data_out != 0) chk("idle_outputs", {finish, data_out}, 0);
            if (result_valid) begin
                rv_seen++;
                if (exp_r.size() == 0) chk("stray_result_valid", 1, 0);
                else begin
                    mr = exp_r.pop_front();
                    chk("result", result, mr.r);
                    chk("result_err", result_err, mr.e);
`ifdef RANGE_FRAME_TX_EXPECT_EN
                    chk("expected", expected, mr.x);
                    chk("mismatch", mismatch, mr.m);
`endif
                end
            end
`ifdef RANGE_FRAME_TX_EXPECT_EN
            else if (mismatch) chk("mismatch_without_valid", mismatch, 0);
`endif
            if (reject) begin
                chk("reject_expected", exp_rej > 0, 1);
                if (exp_rej > 0) exp_rej--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2;
        chk("rst_flags", {busy, reject, go, finish, result_valid, result_err, full}, 0);
        chk("rst_data", data_out, 0);
        chk("rst_result", result, 0);
        chk("rst_count", count, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        write(8'd5); write(8'd9); write(8'd2); write(8'd7);
        level();
        do_send(0, '0);
        level();
        write(8'd33);
        do_send(0, '0);
        level();
        for (int i = 0; i < D - 1; i++) write(W'(i * 3 + 1));
        level();
        write(8'hAA);
        level();
        do_send(0, '0);
        level();
        for (int i = 0; i < D; i++) write(W'($urandom));
        level();
        do_send(0, '0);
        for (int i = 0; i < 4; i++) write(W'(i + 40));
        start_send(0, '0);
        write(8'd77);
        write(8'd88);
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        wait_idle();
        level();
        do_send(0, '0);
        write(8'd10); write(8'd4); write(8'd20);
        do_send(1, 8'd3);
        for (int i = 0; i < 6; i++) write(W'($urandom));
        start_send(0, '0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_go_finish_busy", {go, finish, busy}, 0);
        chk("arst_data", data_out, 0);
        chk("arst_count", count, 0);
        mq.delete();
        exp_s.delete();
        exp_r.delete();
        rv_seen = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_result_after_reset", rv_seen, 0);
        level();
        repeat (30) begin
            n = $urandom_range(0, D + 2);
            for (int i = 0; i < n; i++) write(W'($urandom));
            level();
            do_send(0, '0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("samples_left", exp_s.size(), 0);
        chk("results_left", exp_r.size(), 0);
        chk("rejects_pending", exp_rej, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
